// File: rtl/cmd_decoder_if.sv
// Byte-stream command bus: received bytes in, decoded motion/speed state and status pulses out.
interface cmd_decoder_if #(
    parameter int unsigned SPEED_W = 4
);
    logic [7:0]         rx_data;
    logic               rx_valid;
    logic [3:0]         action;
    logic [SPEED_W-1:0] speed;
    logic               cmd_ack;
    logic               cmd_err;
    logic               timeout_flag;

    modport master (
        output rx_data, rx_valid,
        input  action, speed, cmd_ack, cmd_err, timeout_flag
    );

    modport slave (
        input  rx_data, rx_valid,
        output action, speed, cmd_ack, cmd_err, timeout_flag
    );
endinterface

// File: rtl/cmd_decoder.sv
// ASCII command decoder: single-byte motion commands, 'V'<digit> speed commands and an
// inactivity watchdog that forces a stop when no command is accepted for TIMEOUT_CYC cycles.
module cmd_decoder #(
    parameter int unsigned TIMEOUT_CYC = 50_000_000,
    parameter int unsigned SPEED_W     = 4
) (
    input logic          clk,
    input logic          rst_n,
    cmd_decoder_if.slave bus
);
    localparam int unsigned CntW       = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT_CYC);
    localparam bit          WdEn       = (TIMEOUT_CYC != 0);
    localparam int unsigned MaxSpeed   = (1 << SPEED_W) - 1;

    typedef enum logic [0:0] {StIdle, StWaitArg} state_e;

    state_e             state_q, state_d;
    logic [3:0]         action_q, action_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic               ack_q, ack_d;
    logic               err_q, err_d;
    logic               flag_q, flag_d;
    logic [CntW-1:0]    cnt_q, cnt_d;

    logic       is_action, is_digit, is_eol, is_speed_cmd, expire;
    logic [3:0] act_map;
    logic [3:0] digit;

    always_comb begin
        is_action = 1'b1;
        act_map   = 4'b0000;
        unique case (bus.rx_data)
            8'h31:               act_map = 4'b0001;
            8'h32:               act_map = 4'b0100;
            8'h33:               act_map = 4'b1000;
            8'h34:               act_map = 4'b0010;
            8'h30, 8'h53, 8'h73: act_map = 4'b0000;
            default:             is_action = 1'b0;
        endcase
        is_digit     = (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39);
        is_eol       = (bus.rx_data == 8'h0D) || (bus.rx_data == 8'h0A);
        is_speed_cmd = (bus.rx_data == 8'h56) || (bus.rx_data == 8'h76);
        digit        = bus.rx_data[3:0];
    end

    always_comb begin
        state_d  = state_q;
        action_d = action_q;
        speed_d  = speed_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        flag_d   = flag_q;
        cnt_d    = cnt_q;
        expire   = 1'b0;

        if (bus.rx_valid && !is_eol) begin
            if (state_q == StIdle) begin
                if (is_action) begin
                    action_d = act_map;
                    ack_d    = 1'b1;
                    flag_d   = 1'b0;
                end else if (is_speed_cmd) begin
                    state_d = StWaitArg;
                end else begin
                    err_d = 1'b1;
                end
            end else begin
                state_d = StIdle;
                if (is_digit) begin
                    if (32'(digit) > MaxSpeed) speed_d = SPEED_W'(MaxSpeed);
                    else                       speed_d = SPEED_W'(digit);
                    ack_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
        end

        if (ack_d)                    cnt_d = '0;
        else if (cnt_q != TimeoutVal) cnt_d = cnt_q + CntW'(1);

        // Fires once per stall: after the stop is forced, the saturated counter must not keep
        // kicking a pending 'V' argument out of WAIT_ARG. Any accepted command wins the race.
        expire = WdEn && (cnt_q == TimeoutVal) && !flag_q && !ack_d;
        if (expire) begin
            action_d = 4'b0000;
            flag_d   = 1'b1;
            state_d  = StIdle;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            action_q <= 4'b0000;
            speed_q  <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            flag_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            action_q <= action_d;
            speed_q  <= speed_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            flag_q   <= flag_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.action       = action_q;
    assign bus.speed        = speed_q;
    assign bus.cmd_ack      = ack_q;
    assign bus.cmd_err      = err_q;
    assign bus.timeout_flag = flag_q;
endmodule

// File: tb/tb_cmd_decoder.sv
// Bench for cmd_decoder: two instances (watchdog 16 and disabled) driven by one byte stream,
// checked every cycle against a behavioural model plus hand-computed directed expectations.
module tb_cmd_decoder;
    localparam int unsigned SpeedW = 4;

    typedef struct packed {
        logic       waiting;
        logic [3:0] act;
        int         spd;
        logic       ack;
        logic       err;
        logic       flag;
        int         cnt;
    } mdl_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    int         n_checks;
    int         n_fail;
    mdl_t       m16;
    mdl_t       m0;

    cmd_decoder_if #(.SPEED_W(SpeedW)) bus16 ();
    cmd_decoder_if #(.SPEED_W(SpeedW)) bus0 ();

    assign bus16.rx_data  = rx_data;
    assign bus16.rx_valid = rx_valid;
    assign bus0.rx_data   = rx_data;
    assign bus0.rx_valid  = rx_valid;

    cmd_decoder #(.TIMEOUT_CYC(16), .SPEED_W(SpeedW)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16)
    );

    cmd_decoder #(.TIMEOUT_CYC(0), .SPEED_W(SpeedW)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] act_of(logic [7:0] b);
        case (b)
            8'h31:   return 4'b0001;
            8'h32:   return 4'b0100;
            8'h33:   return 4'b1000;
            8'h34:   return 4'b0010;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic mdl_t step(mdl_t m, logic v, logic [7:0] b, int tmo);
        mdl_t n;
        bit   expired;
        n       = m;
        n.ack   = 1'b0;
        n.err   = 1'b0;
        expired = (tmo != 0) && (m.cnt == tmo) && !m.flag;
        if (v && b != 8'h0D && b != 8'h0A) begin
            if (!m.waiting) begin
                if (b inside {8'h31, 8'h32, 8'h33, 8'h34, 8'h30, 8'h53, 8'h73}) begin
                    n.act  = act_of(b);
                    n.ack  = 1'b1;
                    n.flag = 1'b0;
                end else if (b == 8'h56 || b == 8'h76) begin
                    n.waiting = 1'b1;
                end else begin
                    n.err = 1'b1;
                end
            end else begin
                n.waiting = 1'b0;
                if (b >= 8'h30 && b <= 8'h39) begin
                    n.spd = (int'(b) - 48 > (1 << SpeedW) - 1) ? (1 << SpeedW) - 1 : int'(b) - 48;
                    n.ack = 1'b1;
                end else begin
                    n.err = 1'b1;
                end
            end
        end
        if (n.ack)             n.cnt = 0;
        else if (m.cnt < tmo)  n.cnt = m.cnt + 1;
        if (expired && !n.ack) begin
            n.act     = 4'b0000;
            n.flag    = 1'b1;
            n.waiting = 1'b0;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m16 <= '0;
            m0  <= '0;
        end else begin
            m16 <= step(m16, rx_valid, rx_data, 16);
            m0  <= step(m0, rx_valid, rx_data, 0);
        end
    end

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("action16", 32'(bus16.action), 32'(m16.act));
        check("speed16", 32'(bus16.speed), 32'(m16.spd));
        check("ack16", 32'(bus16.cmd_ack), 32'(m16.ack));
        check("err16", 32'(bus16.cmd_err), 32'(m16.err));
        check("flag16", 32'(bus16.timeout_flag), 32'(m16.flag));
        check("ack_err_excl16", 32'(bus16.cmd_ack & bus16.cmd_err), 32'd0);
        check("action0", 32'(bus0.action), 32'(m0.act));
        check("speed0", 32'(bus0.speed), 32'(m0.spd));
        check("ack0", 32'(bus0.cmd_ack), 32'(m0.ack));
        check("err0", 32'(bus0.cmd_err), 32'(m0.err));
        check("flag0", 32'(bus0.timeout_flag), 32'(m0.flag));
    endtask

    // Called at a falling edge: drive the byte, let one rising edge consume it, check.
    task automatic tick(logic v, logic [7:0] b);
        rx_valid = v;
        rx_data  = b;
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00);
    endtask

    logic [7:0] pool [16];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        pool = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h30, 8'h53, 8'h73, 8'h56,
                 8'h76, 8'h0D, 8'h0A, 8'h35, 8'h39, 8'h37, 8'h58, 8'h20};
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_action", 32'(bus16.action), 32'd0);
        check("rst_speed", 32'(bus16.speed), 32'd0);
        check("rst_ack", 32'(bus16.cmd_ack), 32'd0);
        check("rst_err", 32'(bus16.cmd_err), 32'd0);
        check("rst_flag", 32'(bus16.timeout_flag), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Action map, one byte per cycle.
        tick(1'b1, 8'h31); check("seq_1", 32'(bus16.action), 32'b0001);
        check("seq_1_ack", 32'(bus16.cmd_ack), 32'd1);
        tick(1'b1, 8'h32); check("seq_2", 32'(bus16.action), 32'b0100);
        tick(1'b1, 8'h33); check("seq_3", 32'(bus16.action), 32'b1000);
        tick(1'b1, 8'h34); check("seq_4", 32'(bus16.action), 32'b0010);
        tick(1'b1, 8'h53); check("seq_S", 32'(bus16.action), 32'b0000);
        check("seq_S_err", 32'(bus16.cmd_err), 32'd0);

        // Speed commands, bad argument, CR inside a speed command.
        tick(1'b1, 8'h56); check("V_noack", 32'(bus16.cmd_ack), 32'd0);
        tick(1'b1, 8'h37); check("speed7", 32'(bus16.speed), 32'd7);
        check("speed7_ack", 32'(bus16.cmd_ack), 32'd1);
        tick(1'b1, 8'h76);
        tick(1'b1, 8'h58); check("badarg_err", 32'(bus16.cmd_err), 32'd1);
        check("badarg_speed", 32'(bus16.speed), 32'd7);
        tick(1'b1, 8'h56);
        tick(1'b1, 8'h0D); check("cr_noerr", 32'(bus16.cmd_err), 32'd0);
        tick(1'b1, 8'h39); check("speed9", 32'(bus16.speed), 32'd9);

        // Watchdog: counter 0 after the ack, reaches 16 after 16 idle edges, stop on the next.
        tick(1'b1, 8'h31);
        idle(16);
        check("wd_pre_action", 32'(bus16.action), 32'b0001);
        check("wd_pre_flag", 32'(bus16.timeout_flag), 32'd0);
        idle(1);
        check("wd_action", 32'(bus16.action), 32'b0000);
        check("wd_flag", 32'(bus16.timeout_flag), 32'd1);
        tick(1'b1, 8'h56);
        tick(1'b1, 8'h35); check("wd_speed5", 32'(bus16.speed), 32'd5);
        check("wd_flag_kept", 32'(bus16.timeout_flag), 32'd1);
        tick(1'b1, 8'h32); check("wd_clear_act", 32'(bus16.action), 32'b0100);
        check("wd_clear_flag", 32'(bus16.timeout_flag), 32'd0);

        // Command in the expiry cycle wins and reloads the counter.
        idle(16);
        tick(1'b1, 8'h33); check("race_action", 32'(bus16.action), 32'b1000);
        check("race_flag", 32'(bus16.timeout_flag), 32'd0);
        idle(16); check("race_reload", 32'(bus16.timeout_flag), 32'd0);
        idle(1);  check("race_expire", 32'(bus16.timeout_flag), 32'd1);

        // Watchdog disabled instance.
        tick(1'b1, 8'h34);
        idle(1000);
        check("nowd_action", 32'(bus0.action), 32'b0010);
        check("nowd_flag", 32'(bus0.timeout_flag), 32'd0);

        // Mid-cycle reset while an argument is pending.
        tick(1'b1, 8'h31);
        tick(1'b1, 8'h56);
        rx_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_action", 32'(bus16.action), 32'd0);
        check("arst_speed", 32'(bus16.speed), 32'd0);
        check("arst_flag", 32'(bus16.timeout_flag), 32'd0);
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;
        tick(1'b1, 8'h35); check("arst_err", 32'(bus16.cmd_err), 32'd1);
        check("arst_speed0", 32'(bus16.speed), 32'd0);

        // Randomized traffic with occasional long gaps and resets.
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 3) begin
                idle($urandom_range(10, 24));
            end else if (r < 4) begin
                rx_valid = 1'b0;
                @(posedge clk);
                #2 rst_n = 1'b0;
                @(negedge clk);
                compare_all();
                rst_n = 1'b1;
            end else begin
                logic [7:0] b;
                if ($urandom_range(0, 9) < 7) b = pool[$urandom_range(0, 15)];
                else                          b = 8'($urandom_range(0, 255));
                tick(1'($urandom_range(0, 3) != 0), b);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
